// File: rtl/cernbe_pkg.sv
// ---------------------------------------------------------------------------
// cernbe_pkg
// Shared definitions for the CERN-BE register bus initiator: the bus data
// width and the state encoding of the master's transaction FSM.
// ---------------------------------------------------------------------------
package cernbe_pkg;

   // CERN-BE data path width in bits
   localparam int CERNBE_DATA_W = 32;

   // Master FSM: idle, waiting for a read or write Done, presenting a response
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RSP     = 2'd3
   } cernbe_state_e;

endpackage

// File: rtl/cernbe_timeout.sv
// ---------------------------------------------------------------------------
// cernbe_timeout
// Cycle counter guarding a bus cycle against a responder that never answers.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clear_i      restart the count at zero (issued with the bus strobe)
//   enable_i     count one more cycle spent waiting for Done
//   expired_o    count has reached TIMEOUT; held at 0 when TIMEOUT is 0
// ---------------------------------------------------------------------------
module cernbe_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          at_limit;

   // The limit compare is gated by TIMEOUT so a zero setting never expires;
   // the counter then simply wraps, which is harmless.
   assign at_limit  = (count_q == CW'(TIMEOUT));
   assign expired_o = (TIMEOUT != 0) && at_limit;

   // Clear dominates; counting stops once the limit is reached
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/cernbe_master.sv
// ---------------------------------------------------------------------------
// cernbe_master
// Initiator for the CERN-BE register bus. Takes one read/write command at a
// time, strobes the bus for one cycle, holds address/data until Done and
// returns read data or a timeout error on a valid/ready response port.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o    command handshake
//   cmd_we_i, cmd_addr_i,      direction (1 = write), word address,
//   cmd_wdata_i                write data
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_rdata_o, rsp_err_o     read data (0 on write/error), timeout flag
//   VMEAddr, VMEWrData         registered bus address / write data
//   VMERdMem, VMEWrMem         one-cycle read / write strobes
//   VMERdData, VMERdDone,      responder read data and completion pulses
//   VMEWrDone
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module cernbe_master
   import cernbe_pkg::*;
#(
   parameter int ADDR_WIDTH = 20,
   parameter int TIMEOUT    = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic                     cmd_we_i,
   input  logic [ADDR_WIDTH-1:2]    cmd_addr_i,
   input  logic [CERNBE_DATA_W-1:0] cmd_wdata_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [CERNBE_DATA_W-1:0] rsp_rdata_o,
   output logic                     rsp_err_o,
   output logic [ADDR_WIDTH-1:2]    VMEAddr,
   output logic [CERNBE_DATA_W-1:0] VMEWrData,
   output logic                     VMERdMem,
   output logic                     VMEWrMem,
   input  logic [CERNBE_DATA_W-1:0] VMERdData,
   input  logic                     VMERdDone,
   input  logic                     VMEWrDone
);

   cernbe_state_e             state_q, state_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic                      rd_mem_q, rd_mem_d;
   logic                      wr_mem_q, wr_mem_d;
   logic [ADDR_WIDTH-1:2]     addr_q, addr_d;
   logic [CERNBE_DATA_W-1:0]  wdata_q, wdata_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [CERNBE_DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                      rsp_err_q, rsp_err_d;
   logic                      tmo_clear, tmo_enable, tmo_expired;

   cernbe_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (tmo_clear),
      .enable_i  (tmo_enable),
      .expired_o (tmo_expired)
   );

   // Next-state and registered-output logic. The WAIT states are entered on
   // the same edge that raises the strobe, so Done is already looked at
   // during the strobe cycle. Done is checked before the timeout so a
   // completion in the expiry cycle still counts as success.
   always_comb begin
      state_d     = state_q;
      rd_mem_d    = 1'b0;
      wr_mem_d    = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      tmo_clear   = 1'b0;
      tmo_enable  = 1'b0;

      case (state_q)
         IDLE: begin
            // cmd_ready_q is only high in IDLE, and stays low for the first
            // cycle after reset release
            if (cmd_valid_i && cmd_ready_q) begin
               addr_d    = cmd_addr_i;
               wdata_d   = cmd_wdata_i;
               tmo_clear = 1'b1;
               if (cmd_we_i) begin
                  wr_mem_d = 1'b1;
                  state_d  = WR_WAIT;
               end else begin
                  rd_mem_d = 1'b1;
                  state_d  = RD_WAIT;
               end
            end
         end

         RD_WAIT: begin
            if (VMERdDone) begin
               rsp_rdata_d = VMERdData;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else if (tmo_expired) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else begin
               tmo_enable = 1'b1;
            end
         end

         WR_WAIT: begin
            if (VMEWrDone) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else if (tmo_expired) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end else begin
               tmo_enable = 1'b1;
            end
         end

         RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Ready is registered, so derive it from where the FSM is heading
      cmd_ready_d = (state_d == IDLE);
   end

   // State and output registers; reset drops any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         rd_mem_q    <= 1'b0;
         wr_mem_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rd_mem_q    <= rd_mem_d;
         wr_mem_q    <= wr_mem_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready_o = cmd_ready_q;
   assign VMERdMem    = rd_mem_q;
   assign VMEWrMem    = wr_mem_q;
   assign VMEAddr     = addr_q;
   assign VMEWrData   = wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_cernbe_master.sv
// ---------------------------------------------------------------------------
// tb_cernbe_master
// Directed bench for cernbe_master. The main instance runs with TIMEOUT=16;
// a second instance with TIMEOUT=3 covers the Done-versus-expiry race.
// Inputs change 1 time unit after the rising edge and outputs are read
// there too, so every value seen is the one registered by that edge.
// ---------------------------------------------------------------------------
module tb_cernbe_master;

   localparam int AW = 20;

   logic          clk;
   logic          rst_n;

   // Main instance (TIMEOUT=16)
   logic          cmdValid, cmdReady, cmdWe;
   logic [AW-1:2] cmdAddr;
   logic [31:0]   cmdWdata;
   logic          rspValid, rspReady, rspErr;
   logic [31:0]   rspRdata;
   logic [AW-1:2] vmeAddr;
   logic [31:0]   vmeWrData, vmeRdData;
   logic          vmeRdMem, vmeWrMem, vmeRdDone, vmeWrDone;

   // Short-timeout instance (TIMEOUT=3)
   logic          bCmdValid, bCmdReady, bCmdWe;
   logic [AW-1:2] bCmdAddr;
   logic [31:0]   bCmdWdata;
   logic          bRspValid, bRspReady, bRspErr;
   logic [31:0]   bRspRdata;
   logic [AW-1:2] bVmeAddr;
   logic [31:0]   bVmeWrData, bVmeRdData;
   logic          bVmeRdMem, bVmeWrMem, bVmeRdDone, bVmeWrDone;

   int checkCount;
   int errorCount;

   cernbe_master #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid_i (cmdValid),
      .cmd_ready_o (cmdReady),
      .cmd_we_i    (cmdWe),
      .cmd_addr_i  (cmdAddr),
      .cmd_wdata_i (cmdWdata),
      .rsp_valid_o (rspValid),
      .rsp_ready_i (rspReady),
      .rsp_rdata_o (rspRdata),
      .rsp_err_o   (rspErr),
      .VMEAddr     (vmeAddr),
      .VMEWrData   (vmeWrData),
      .VMERdMem    (vmeRdMem),
      .VMEWrMem    (vmeWrMem),
      .VMERdData   (vmeRdData),
      .VMERdDone   (vmeRdDone),
      .VMEWrDone   (vmeWrDone)
   );

   cernbe_master #(.ADDR_WIDTH(AW), .TIMEOUT(3)) dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid_i (bCmdValid),
      .cmd_ready_o (bCmdReady),
      .cmd_we_i    (bCmdWe),
      .cmd_addr_i  (bCmdAddr),
      .cmd_wdata_i (bCmdWdata),
      .rsp_valid_o (bRspValid),
      .rsp_ready_i (bRspReady),
      .rsp_rdata_o (bRspRdata),
      .rsp_err_o   (bRspErr),
      .VMEAddr     (bVmeAddr),
      .VMEWrData   (bVmeWrData),
      .VMERdMem    (bVmeRdMem),
      .VMEWrMem    (bVmeWrMem),
      .VMERdData   (bVmeRdData),
      .VMERdDone   (bVmeRdDone),
      .VMEWrDone   (bVmeWrDone)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command on the main instance for the coming edge
   task automatic applyStimulus(input logic we, input logic [AW-1:2] addr,
                                input logic [31:0] wdata);
      cmdValid = 1'b1;
      cmdWe    = we;
      cmdAddr  = addr;
      cmdWdata = wdata;
   endtask

   // Safety net against a stuck simulation
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst_n      = 1'b0;
      cmdValid = 1'b0; cmdWe = 1'b0; cmdAddr = '0; cmdWdata = '0;
      rspReady = 1'b0; vmeRdData = '0; vmeRdDone = 1'b0; vmeWrDone = 1'b0;
      bCmdValid = 1'b0; bCmdWe = 1'b0; bCmdAddr = '0; bCmdWdata = '0;
      bRspReady = 1'b0; bVmeRdData = '0; bVmeRdDone = 1'b0; bVmeWrDone = 1'b0;

      // ---- Reset state ----
      tick();
      tick();
      checkOutput("rst cmd_ready", {31'd0, cmdReady}, 32'd0);
      checkOutput("rst rdmem",     {31'd0, vmeRdMem}, 32'd0);
      checkOutput("rst wrmem",     {31'd0, vmeWrMem}, 32'd0);
      checkOutput("rst rsp_valid", {31'd0, rspValid}, 32'd0);
      checkOutput("rst rsp_err",   {31'd0, rspErr},   32'd0);
      checkOutput("rst rdata",     rspRdata,          32'd0);
      checkOutput("rst addr",      32'(vmeAddr),      32'd0);
      checkOutput("rst wrdata",    vmeWrData,         32'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("post-rst cmd_ready", {31'd0, cmdReady}, 32'd1);

      // ---- Read at byte 0x4, responder answers one cycle after strobe ----
      applyStimulus(1'b0, 18'd1, 32'h0);
      tick();                                   // cycle N+1
      cmdValid = 1'b0;
      checkOutput("rd strobe",      {31'd0, vmeRdMem}, 32'd1);
      checkOutput("rd no wrstrobe", {31'd0, vmeWrMem}, 32'd0);
      checkOutput("rd addr N+1",    32'(vmeAddr),      32'd1);
      checkOutput("rd busy",        {31'd0, cmdReady}, 32'd0);
      tick();                                   // cycle N+2
      checkOutput("rd strobe end",  {31'd0, vmeRdMem}, 32'd0);
      checkOutput("rd addr N+2",    32'(vmeAddr),      32'd1);
      checkOutput("rd no rsp N+2",  {31'd0, rspValid}, 32'd0);
      vmeRdDone = 1'b1;
      vmeRdData = 32'hCAFE0001;
      tick();                                   // cycle N+3
      vmeRdDone = 1'b0;
      vmeRdData = 32'hDEADBEEF;
      checkOutput("rd rsp_valid N+3", {31'd0, rspValid}, 32'd1);
      checkOutput("rd rdata",         rspRdata,          32'hCAFE0001);
      checkOutput("rd err",           {31'd0, rspErr},   32'd0);
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      checkOutput("rd rsp done",   {31'd0, rspValid}, 32'd0);
      checkOutput("rd ready back", {31'd0, cmdReady}, 32'd1);

      // ---- Write 0x12345678 at byte 0x8, Done five cycles after strobe ----
      applyStimulus(1'b1, 18'd2, 32'h12345678);
      tick();                                   // strobe cycle
      cmdValid = 1'b0;
      cmdWdata = 32'h0;
      checkOutput("wr strobe",      {31'd0, vmeWrMem}, 32'd1);
      checkOutput("wr no rdstrobe", {31'd0, vmeRdMem}, 32'd0);
      checkOutput("wr addr",        32'(vmeAddr),      32'd2);
      checkOutput("wr data c1",     vmeWrData,         32'h12345678);
      for (int i = 2; i <= 6; i++) begin
         tick();
         checkOutput("wr strobe low", {31'd0, vmeWrMem}, 32'd0);
         checkOutput("wr data held",  vmeWrData,         32'h12345678);
         checkOutput("wr addr held",  32'(vmeAddr),      32'd2);
         checkOutput("wr no rsp yet", {31'd0, rspValid}, 32'd0);
         if (i == 6) vmeWrDone = 1'b1;
      end
      tick();
      vmeWrDone = 1'b0;
      checkOutput("wr rsp_valid", {31'd0, rspValid}, 32'd1);
      checkOutput("wr err",       {31'd0, rspErr},   32'd0);
      checkOutput("wr rdata",     rspRdata,          32'd0);
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      checkOutput("wr rsp done", {31'd0, rspValid}, 32'd0);

      // ---- Read with no responder, TIMEOUT=16: error in cycle N+18 ----
      applyStimulus(1'b0, 18'h3FFFF, 32'h0);
      tick();                                   // N+1
      cmdValid = 1'b0;
      for (int c = 2; c <= 17; c++) begin
         tick();
         checkOutput("tmo waiting", {31'd0, rspValid}, 32'd0);
      end
      tick();                                   // N+18
      checkOutput("tmo rsp_valid", {31'd0, rspValid}, 32'd1);
      checkOutput("tmo err",       {31'd0, rspErr},   32'd1);
      checkOutput("tmo rdata",     rspRdata,          32'd0);
      checkOutput("tmo addr max",  32'(vmeAddr),      32'h3FFFF);
      rspReady = 1'b1;
      tick();                                   // N+19
      rspReady = 1'b0;
      tick();                                   // N+20: late Done
      vmeRdDone = 1'b1;
      vmeRdData = 32'h0BADF00D;
      tick();                                   // N+21
      vmeRdDone = 1'b0;
      checkOutput("late done no rsp", {31'd0, rspValid}, 32'd0);
      checkOutput("late done idle",   {31'd0, cmdReady}, 32'd1);
      tick();
      checkOutput("late done still",  {31'd0, rspValid}, 32'd0);

      // ---- Wrong-kind Done ignored, response held under backpressure ----
      applyStimulus(1'b0, 18'h00155, 32'h0);
      tick();                                   // N+1
      cmdValid  = 1'b0;
      vmeWrDone = 1'b1;
      checkOutput("wk busy N+1", {31'd0, cmdReady}, 32'd0);
      tick();                                   // N+2
      vmeWrDone = 1'b0;
      checkOutput("wk wrdone ignored", {31'd0, rspValid}, 32'd0);
      checkOutput("wk busy N+2",       {31'd0, cmdReady}, 32'd0);
      tick();                                   // N+3
      vmeRdDone = 1'b1;
      vmeRdData = 32'hA5A50F0F;
      checkOutput("wk no rsp N+3", {31'd0, rspValid}, 32'd0);
      checkOutput("wk busy N+3",   {31'd0, cmdReady}, 32'd0);
      tick();                                   // N+4
      vmeRdDone = 1'b0;
      vmeRdData = 32'h11111111;
      for (int h = 0; h < 3; h++) begin
         checkOutput("wk rsp held",  {31'd0, rspValid}, 32'd1);
         checkOutput("wk rdata held", rspRdata,         32'hA5A50F0F);
         checkOutput("wk err",       {31'd0, rspErr},   32'd0);
         checkOutput("wk busy rsp",  {31'd0, cmdReady}, 32'd0);
         if (h == 2) rspReady = 1'b1;
         tick();
      end
      rspReady = 1'b0;
      checkOutput("wk rsp taken",  {31'd0, rspValid}, 32'd0);
      checkOutput("wk ready back", {31'd0, cmdReady}, 32'd1);

      // ---- Reset asserted during a write ----
      applyStimulus(1'b1, 18'h00AAA, 32'h55AA55AA);
      tick();                                   // strobe cycle
      cmdValid = 1'b0;
      checkOutput("rstwr strobe", {31'd0, vmeWrMem}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rstwr strobe drop", {31'd0, vmeWrMem}, 32'd0);
      checkOutput("rstwr no rsp",      {31'd0, rspValid}, 32'd0);
      checkOutput("rstwr not ready",   {31'd0, cmdReady}, 32'd0);
      checkOutput("rstwr addr clr",    32'(vmeAddr),      32'd0);
      checkOutput("rstwr data clr",    vmeWrData,         32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("rstwr ready after", {31'd0, cmdReady}, 32'd1);
      vmeWrDone = 1'b1;
      tick();
      vmeWrDone = 1'b0;
      checkOutput("rstwr stray done", {31'd0, rspValid}, 32'd0);
      tick();
      checkOutput("rstwr no rsp later", {31'd0, rspValid}, 32'd0);
      checkOutput("rstwr no strobe",    {31'd0, vmeWrMem}, 32'd0);

      // ---- TIMEOUT=3: Done in the expiry cycle wins ----
      bCmdValid = 1'b1; bCmdWe = 1'b1; bCmdAddr = 18'h00123;
      bCmdWdata = 32'hFEEDC0DE;
      tick();                                   // N+1, count 0
      bCmdValid = 1'b0;
      checkOutput("b strobe",  {31'd0, bVmeWrMem}, 32'd1);
      checkOutput("b rdmem",   {31'd0, bVmeRdMem}, 32'd0);
      checkOutput("b addr",    32'(bVmeAddr),      32'h00123);
      checkOutput("b wrdata",  bVmeWrData,         32'hFEEDC0DE);
      tick();                                   // N+2, count 1
      tick();                                   // N+3, count 2
      tick();                                   // N+4, count 3
      checkOutput("b no rsp N+4", {31'd0, bRspValid}, 32'd0);
      bVmeWrDone = 1'b1;
      tick();                                   // N+5
      bVmeWrDone = 1'b0;
      checkOutput("b race valid", {31'd0, bRspValid}, 32'd1);
      checkOutput("b race err",   {31'd0, bRspErr},   32'd0);
      checkOutput("b race rdata", bRspRdata,          32'd0);
      bRspReady = 1'b1;
      tick();
      bRspReady = 1'b0;
      checkOutput("b ready back", {31'd0, bCmdReady}, 32'd1);

      // ---- TIMEOUT=3: plain expiry on a read, error in cycle N+5 ----
      bCmdValid = 1'b1; bCmdWe = 1'b0; bCmdAddr = 18'h00010;
      tick();                                   // N+1
      bCmdValid = 1'b0;
      tick(); tick(); tick();                   // N+4
      checkOutput("b tmo not yet", {31'd0, bRspValid}, 32'd0);
      tick();                                   // N+5
      checkOutput("b tmo valid", {31'd0, bRspValid}, 32'd1);
      checkOutput("b tmo err",   {31'd0, bRspErr},   32'd1);
      checkOutput("b tmo rdata", bRspRdata,          32'd0);
      bRspReady = 1'b1;
      tick();
      bRspReady = 1'b0;

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
